// File: rtl/sdf_stage_sched_pkg.sv
// Shared types and width helpers for the SDF stage scheduler.
//   sched_state_t : scheduler FSM states
//   tag_t         : {valid, start-of-frame} tag carried alongside the CORDIC pipeline
//   cnt_w / tw_w  : sample-counter and twiddle-index widths for an N-point stage
package fft_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;

  typedef struct packed {
    logic v;
    logic sop;
  } tag_t;

  // Sample counter covers 0..N-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n);
  endfunction

  // Twiddle index only ever addresses the first half of the frame (0..N/2-1).
  function automatic int unsigned tw_w(input int unsigned n);
    return $clog2(n) - 1;
  endfunction

endpackage

// File: rtl/sdf_stage_sched_if.sv
// Handshake/control bundle between the sample source and the SDF stage scheduler.
//   i_valid, i_sop                 : source -> scheduler
//   o_adv, o_bf_sel, o_tw_idx,
//   o_tw_en, o_valid, o_sop,
//   o_busy, o_err                  : scheduler -> datapath / sink
//   o_frame_cnt, o_stall_cnt       : statistics, present only with SDF_SCHED_STATS_EN
// modport master: drives the inputs (source side); modport slave: the scheduler.
interface sdf_stage_sched_if #(
  parameter int unsigned N = 64
);
  import fft_sched_pkg::*;

  localparam int unsigned TW_W = tw_w(N);

  logic            i_valid;
  logic            i_sop;
  logic            o_adv;
  logic            o_bf_sel;
  logic [TW_W-1:0] o_tw_idx;
  logic            o_tw_en;
  logic            o_valid;
  logic            o_sop;
  logic            o_busy;
  logic            o_err;
`ifdef SDF_SCHED_STATS_EN
  logic [15:0]     o_frame_cnt;
  logic [15:0]     o_stall_cnt;

  modport master (
    output i_valid, i_sop,
    input  o_adv, o_bf_sel, o_tw_idx, o_tw_en, o_valid, o_sop, o_busy, o_err,
    input  o_frame_cnt, o_stall_cnt
  );
  modport slave (
    input  i_valid, i_sop,
    output o_adv, o_bf_sel, o_tw_idx, o_tw_en, o_valid, o_sop, o_busy, o_err,
    output o_frame_cnt, o_stall_cnt
  );
`else
  modport master (
    output i_valid, i_sop,
    input  o_adv, o_bf_sel, o_tw_idx, o_tw_en, o_valid, o_sop, o_busy, o_err
  );
  modport slave (
    input  i_valid, i_sop,
    output o_adv, o_bf_sel, o_tw_idx, o_tw_en, o_valid, o_sop, o_busy, o_err
  );
`endif

endinterface

// File: rtl/sdf_stage_sched_tag_delay.sv
// tag_delay: LAT-stage shift register of tag_t that mirrors the free-running CORDIC latency.
//   i_clk, i_reset : clock, synchronous active-high reset (clears every stage)
//   i_tag          : tag entering the pipeline
//   o_tag          : tag leaving the last stage (registered)
//   o_pend_c       : some stage other than the last holds a non-zero tag
module tag_delay
  import fft_sched_pkg::*;
#(
  parameter int unsigned LAT = 23
) (
  input  logic i_clk,
  input  logic i_reset,
  input  tag_t i_tag,
  output tag_t o_tag,
  output logic o_pend_c
);

  tag_t sr [LAT];

  // Shift every cycle; the rotator never stalls.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < LAT; i++) sr[i] <= '0;
    end else begin
      sr[0] <= i_tag;
      for (int unsigned i = 1; i < LAT; i++) sr[i] <= sr[i-1];
    end
  end

  assign o_tag = sr[LAT-1];

  // Stages that will still be inside the pipeline after the next edge.
  always_comb begin
    o_pend_c = 1'b0;
    for (int unsigned i = 0; i + 1 < LAT; i++) o_pend_c = o_pend_c | (|sr[i]);
  end

endmodule

// File: rtl/sdf_stage_sched.sv
// sdf_stage_sched: control sequencer for one radix-2 SDF FFT stage. Drives the delay-line
// advance, butterfly/pass select and CORDIC twiddle index, and delays a {valid, sop} tag by
// the rotator latency so the stage output is tagged on the cycle its data emerges.
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : i_valid/i_sop in; o_adv, o_bf_sel, o_tw_idx, o_tw_en, o_valid, o_sop,
//                    o_busy, o_err out (all registered)
// Optional: SDF_SCHED_STATS_EN adds o_frame_cnt (o_sop count, wraps) and o_stall_cnt
// (RUN cycles without i_valid, saturating).
module sdf_stage_sched
  import fft_sched_pkg::*;
#(
  parameter int unsigned N   = 64,
  parameter int unsigned LAT = 23
) (
  input logic i_clk,
  input logic i_reset,
  sdf_stage_sched_if.slave bus
);

  localparam int unsigned CW   = cnt_w(N);
  localparam int unsigned TW_W = tw_w(N);
  localparam int unsigned D    = N / 2;
  localparam logic [CW-1:0]   CNT_D = CW'(D);
  localparam logic [TW_W-1:0] DMAX  = TW_W'(D - 1);

  sched_state_t    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, samp;
  logic [TW_W-1:0] dcnt_q, dcnt_d;
  logic            primed_q, primed_d;
  logic            err_q, err_d;
  logic            issue, drain;

  logic            adv_q, adv_d;
  logic            bf_q, bf_d;
  logic [TW_W-1:0] tw_idx_q, tw_idx_d;
  logic            tw_en_q, tw_en_d;
  tag_t            tag_q, tag_d, tag_out;
  logic            busy_q, busy_d;
  logic            pend_c;

  // Next state, counters and per-cycle issue controls.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dcnt_d   = dcnt_q;
    primed_d = primed_q;
    err_d    = err_q;
    issue    = 1'b0;
    drain    = 1'b0;
    samp     = cnt_q;
    adv_d    = 1'b0;
    bf_d     = 1'b0;
    tw_idx_d = '0;
    tw_en_d  = 1'b0;
    tag_d    = '0;

    case (state_q)
      IDLE: begin
        if (bus.i_valid && bus.i_sop) begin
          issue   = 1'b1;
          samp    = '0;
          cnt_d   = CW'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        // cnt_q == 0 in RUN means the previous frame just completed.
        if (bus.i_valid && (bus.i_sop || cnt_q != '0)) begin
          issue = 1'b1;
          if (bus.i_sop) begin
            samp = '0;
            if (cnt_q != '0) err_d = 1'b1;
          end
          cnt_d = samp + CW'(1);
        end else if (cnt_q == '0) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        if (bus.i_valid && bus.i_sop) begin
          issue   = 1'b1;
          samp    = '0;
          cnt_d   = CW'(1);
          state_d = RUN;
        end else begin
          drain  = 1'b1;
          dcnt_d = dcnt_q + TW_W'(1);
          if (dcnt_q == DMAX) begin
            state_d  = IDLE;
            primed_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      adv_d   = 1'b1;
      bf_d    = (samp >= CNT_D);
      tw_en_d = ~bf_d;
      if (!bf_d) tw_idx_d = TW_W'(samp);
    end else if (drain) begin
      adv_d    = 1'b1;
      tw_en_d  = 1'b1;
      tw_idx_d = dcnt_q;
    end

    // Pass-mode issues carry the previous frame's diffs, valid only once a frame has primed.
    tag_d.v   = bf_d | (primed_q & adv_d & ~bf_d);
    tag_d.sop = bf_d & (samp == CNT_D);
    if (bf_d) primed_d = 1'b1;

    busy_d = (state_d != IDLE) | (|tag_d) | (|tag_q) | pend_c;
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      primed_q <= 1'b0;
      err_q    <= 1'b0;
      adv_q    <= 1'b0;
      bf_q     <= 1'b0;
      tw_idx_q <= '0;
      tw_en_q  <= 1'b0;
      tag_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      primed_q <= primed_d;
      err_q    <= err_d;
      adv_q    <= adv_d;
      bf_q     <= bf_d;
      tw_idx_q <= tw_idx_d;
      tw_en_q  <= tw_en_d;
      tag_q    <= tag_d;
      busy_q   <= busy_d;
    end
  end

  tag_delay #(.LAT(LAT)) u_tag_delay (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_tag    (tag_q),
    .o_tag    (tag_out),
    .o_pend_c (pend_c)
  );

  assign bus.o_adv    = adv_q;
  assign bus.o_bf_sel = bf_q;
  assign bus.o_tw_idx = tw_idx_q;
  assign bus.o_tw_en  = tw_en_q;
  assign bus.o_valid  = tag_out.v;
  assign bus.o_sop    = tag_out.sop;
  assign bus.o_busy   = busy_q;
  assign bus.o_err    = err_q;

`ifdef SDF_SCHED_STATS_EN
  logic [15:0] frame_cnt_q, stall_cnt_q;

  // Frame counter wraps; stall counter saturates.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (tag_out.sop) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (state_q == RUN && !bus.i_valid && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.o_frame_cnt = frame_cnt_q;
  assign bus.o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sdf_stage_sched.sv
// Directed bench for sdf_stage_sched (N=8, D=4, LAT=23). Each test records 64 cycles of
// outputs as per-cycle bit masks (cycle 0 = first driven cycle after reset) and compares
// them with hand-derived masks.
module tb_sdf_stage_sched;

  localparam int unsigned N   = 8;
  localparam int unsigned LAT = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sdf_stage_sched_if #(.N(N)) bus ();

  sdf_stage_sched #(.N(N), .LAT(LAT)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc;
  int val_tot;
  logic [63:0] adv_m, bf_m, twen_m, val_m, sop_m, busy_m, err_m, any_m, tw_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_rec();
    adv_m = '0; bf_m = '0; twen_m = '0; val_m = '0; sop_m = '0;
    busy_m = '0; err_m = '0; any_m = '0; tw_m = '0;
    cyc = 0;
    val_tot = 0;
  endtask

  // Drive one cycle of inputs, then sample outputs mid-cycle.
  task automatic step(input logic v, input logic s, input logic r);
    @(posedge clk);
    #1;
    bus.i_valid = v;
    bus.i_sop   = s;
    rst         = r;
    @(negedge clk);
    if (cyc < 64) begin
      adv_m[cyc]  = bus.o_adv;
      bf_m[cyc]   = bus.o_bf_sel;
      twen_m[cyc] = bus.o_tw_en;
      val_m[cyc]  = bus.o_valid;
      sop_m[cyc]  = bus.o_sop;
      busy_m[cyc] = bus.o_busy;
      err_m[cyc]  = bus.o_err;
      any_m[cyc]  = |{bus.o_adv, bus.o_bf_sel, bus.o_tw_idx, bus.o_tw_en,
                      bus.o_valid, bus.o_sop, bus.o_busy, bus.o_err};
      if (cyc < 32) tw_m[2*cyc +: 2] = bus.o_tw_idx;
    end
    if (bus.o_valid) val_tot++;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic burst(input int n);
    step(1'b1, 1'b1, 1'b0);
    repeat (n - 1) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    repeat (3) step(1'b0, 1'b0, 1'b1);
    clear_rec();
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_sop   = 1'b0;
    clear_rec();

    // Power-up reset: every output low.
    do_reset();
    check("reset_outs", 64'({bus.o_adv, bus.o_bf_sel, bus.o_tw_idx, bus.o_tw_en,
                             bus.o_valid, bus.o_sop, bus.o_busy, bus.o_err}), 64'd0);

    // Single frame followed by a full drain.
    do_reset();
    burst(8);
    idle(56);
    check("t2_adv",    adv_m,  64'h0000_0000_0000_3DFE);
    check("t2_bf",     bf_m,   64'h0000_0000_0000_01E0);
    check("t2_twen",   twen_m, 64'h0000_0000_0000_3C1E);
    check("t2_tw",     tw_m,   64'h0000_0000_0E40_0390);
    check("t2_valid",  val_m,  64'h0000_001E_F000_0000);
    check("t2_sop",    sop_m,  64'h0000_0000_1000_0000);
    check("t2_busy",   busy_m, 64'h0000_001F_FFFF_FFFE);
    check("t2_nvalid", 64'(val_tot), 64'd8);

    // Three back-to-back frames, one drain at the end.
    do_reset();
    repeat (3) burst(8);
    idle(40);
    check("t3_adv",    adv_m, 64'h0000_0000_3DFF_FFFE);
    check("t3_valid",  val_m, 64'h001E_FFFF_F000_0000);
    check("t3_sop",    sop_m, 64'h0000_1010_1000_0000);
    check("t3_nvalid", 64'(val_tot), 64'd24);

    // Three-cycle stall after cnt reaches 5.
    do_reset();
    burst(5);
    idle(3);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    idle(53);
    check("t4_adv",    adv_m, 64'h0000_0000_0001_EE3E);
    check("t4_bf",     bf_m,  64'h0000_0000_0000_0E20);
    check("t4_valid",  val_m, 64'h0000_00F7_1000_0000);
    check("t4_nvalid", 64'(val_tot), 64'd8);

    // sop arrives with cnt=3: sticky error and resync to the new frame.
    do_reset();
    burst(3);
    burst(8);
    idle(53);
    check("t5_err",    err_m, 64'hFFFF_FFFF_FFFF_FFF0);
    check("t5_sop",    sop_m, 64'h0000_0000_8000_0000);
    check("t5_valid",  val_m, 64'h0000_00F7_8000_0000);
    check("t5_nvalid", 64'(val_tot), 64'd8);

    // New frame enters while draining at dcnt=2.
    do_reset();
    burst(8);
    idle(3);
    burst(8);
    idle(45);
    check("t6_adv",    adv_m,  64'h0000_0000_01EF_FDFE);
    check("t6_tw",     tw_m,   64'h0003_9000_E440_0390);
    check("t6_bf",     bf_m,   64'h0000_0000_000F_01E0);
    check("t6_valid",  val_m,  64'h0000_F7FE_F000_0000);
    check("t6_sop",    sop_m,  64'h0000_0080_1000_0000);
    check("t6_busy",   busy_m, 64'h0000_FFFF_FFFF_FFFE);
    check("t6_nvalid", 64'(val_tot), 64'd18);

    // Reset held 3 cycles mid-frame after a butterfly issue: everything clears.
    do_reset();
    burst(5);
    repeat (3) step(1'b1, 1'b0, 1'b1);
    idle(56);
    check("t1_any",    any_m, 64'h0000_0000_0000_003E);
    check("t1_nvalid", 64'(val_tot), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
